// File: rtl/rram_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter between N_REQ capture
// controllers, sending each granted word MSB byte first. Define RRAM_TX_TAG_EN to prefix each frame with an ASCII id byte.
module rram_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WORD_W  = 64,
  parameter int BUSY_TO = 15,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_word,
  output logic [N_REQ-1:0]        req_ack,
  output logic [7:0]              uart_byte,
  output logic                    uart_start,
  input  logic                    uart_busy,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy
);

  localparam int BYTES = WORD_W / 8;
`ifdef RRAM_TX_TAG_EN
  localparam int FRAME_B = BYTES + 1;
`else
  localparam int FRAME_B = BYTES;
`endif
  localparam int CNT_W = $clog2(FRAME_B + 1);
  localparam int TO_W  = $clog2(BUSY_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_NEXT, S_ACK
  } state_e;

  state_e             state_q;
  logic [IDW-1:0]     ptr_q, grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TO_W-1:0]    to_q;
  logic [WORD_W-1:0]  shadow_q;
  logic [7:0]         uart_byte_q;
  logic               uart_start_q, busy_q;
  logic [N_REQ-1:0]   req_ack_q;
`ifdef RRAM_TX_TAG_EN
  logic               tag_q;
`endif

  logic [IDW-1:0]     grant_d, cand;
  logic               grant_vld_d;
  logic [WORD_W-1:0]  req_arr [N_REQ];
  logic [WORD_W-1:0]  shadow_shift;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_arr[i] = req_word[i*WORD_W +: WORD_W];
  end

  assign shadow_shift = shadow_q << 8;

  // Scan from farthest to nearest so the first set bit after ptr_q wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first, or a latch is inferred.
    grant_vld_d = 1'b0;
    grant_d     = '0;
    cand        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        grant_vld_d = 1'b1;
        grant_d     = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= IDW'(N_REQ - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      shadow_q     <= '0;
      uart_byte_q  <= 8'h00;
      uart_start_q <= 1'b0;
      busy_q       <= 1'b0;
      req_ack_q    <= '0;
`ifdef RRAM_TX_TAG_EN
      tag_q        <= 1'b0;
`endif
    end else begin
      uart_start_q <= 1'b0;
      req_ack_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d && !uart_busy) begin
            shadow_q     <= req_arr[grant_d];
            grant_q      <= grant_d;
            busy_q       <= 1'b1;
            cnt_q        <= CNT_W'(FRAME_B - 1);
            uart_start_q <= 1'b1;
`ifdef RRAM_TX_TAG_EN
            tag_q        <= 1'b1;
            uart_byte_q  <= 8'h30 + 8'(grant_d);
`else
            uart_byte_q  <= req_arr[grant_d][WORD_W-1 -: 8];
`endif
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          to_q    <= '0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A transmitter that never raises busy is assumed to have taken the byte.
          if (uart_busy)                   state_q <= S_WAIT_DONE;
          else if (to_q == TO_W'(BUSY_TO)) state_q <= S_NEXT;
          else                             to_q    <= to_q + TO_W'(1);
        end
        S_WAIT_DONE: begin
          if (!uart_busy) state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (cnt_q == '0) begin
            req_ack_q <= N_REQ'(1) << grant_q;
            state_q   <= S_ACK;
          end else begin
            cnt_q        <= cnt_q - CNT_W'(1);
            uart_start_q <= 1'b1;
            state_q      <= S_LOAD;
`ifdef RRAM_TX_TAG_EN
            if (tag_q) begin
              tag_q       <= 1'b0;
              uart_byte_q <= shadow_q[WORD_W-1 -: 8];
            end else begin
              shadow_q    <= shadow_shift;
              uart_byte_q <= shadow_shift[WORD_W-1 -: 8];
            end
`else
            shadow_q    <= shadow_shift;
            uart_byte_q <= shadow_shift[WORD_W-1 -: 8];
`endif
          end
        end
        S_ACK: begin
          ptr_q   <= grant_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ack    = req_ack_q;
  assign uart_byte  = uart_byte_q;
  assign uart_start = uart_start_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;

endmodule
